// File: rtl/tick_mon_pkg.sv
// tick_mon_pkg: shared state type and width helper for the tick monitor.
package tick_mon_pkg;

  // Lock tracking states of the monitor.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } tick_mon_state_t;

  // Period counter width: must hold MAX_P+1 (the saturation value).
  function automatic int unsigned tick_mon_pw(input int unsigned src_hz,
                                              input int unsigned exp_hz,
                                              input int unsigned tol);
    return unsigned'($clog2((src_hz / exp_hz) + tol + 2));
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: N-flop synchronizer for an asynchronous level plus
// rise/fall detection against a one-cycle history of the synchronized level.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise_c,
  output logic o_fall_c,
  output logic o_level
);

  // Fewer than two stages would not resolve metastability.
  localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [NS-1:0] r_sync;
  logic          r_hist;

  // Shift the async input through the chain; keep last stage history.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[NS-2:0], i_async};
      r_hist <= r_sync[NS-1];
    end
  end

  assign o_level  = r_sync[NS-1];
  assign o_rise_c = r_sync[NS-1] & ~r_hist;
  assign o_fall_c = ~r_sync[NS-1] & r_hist;

endmodule

// File: rtl/tick_monitor.sv
// tick_monitor: synchronizes a divided clock into clk_in, emits a tick per
// rising edge, measures the edge-to-edge period and tracks frequency lock.
// Optional macro TICK_MON_DUTY_EN adds high_cnt_out (high-phase length).
module tick_monitor
  import tick_mon_pkg::*;
#(
  parameter  int unsigned SRC_FREQ_HZ    = 100_000_000,
  parameter  int unsigned EXPECT_FREQ_HZ = 1_000_000,
  parameter  int unsigned TOL_CYCLES     = 2,
  parameter  int unsigned LOCK_COUNT     = 4,
  parameter  int unsigned SYNC_STAGES    = 2,
  localparam int unsigned PW = tick_mon_pw(SRC_FREQ_HZ, EXPECT_FREQ_HZ, TOL_CYCLES)
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          slow_clk_in,
  input  logic          clr_fault,
  output logic          tick,
  output logic [PW-1:0] period_out,
  output logic          period_valid,
  output logic          locked,
  output logic          fault
`ifdef TICK_MON_DUTY_EN
  ,
  output logic [PW-1:0] high_cnt_out
`endif
);

  localparam int unsigned EXP_P = SRC_FREQ_HZ / EXPECT_FREQ_HZ;
  localparam int unsigned MIN_P = EXP_P - TOL_CYCLES;
  localparam int unsigned MAX_P = EXP_P + TOL_CYCLES;
  localparam int unsigned SAT_P = MAX_P + 1;
  // Good-period counter only needs to reach LOCK_COUNT-1 before locking.
  localparam int unsigned GW = (LOCK_COUNT < 2) ? 1 : unsigned'($clog2(LOCK_COUNT));

  logic            w_rise;
  logic            w_fall;
  logic            w_level;
  logic            w_in_range;
  logic            w_timeout;
  logic            w_tracking;
  logic            w_unused;

  logic [PW-1:0]   r_cnt;
  logic [PW-1:0]   r_period;
  logic            r_tick;
  logic            r_pvalid;
  tick_mon_state_t r_state;
  logic [GW-1:0]   r_good;
  logic            r_locked;
  logic            r_fault;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk    (clk_in),
    .i_rst_n  (rst_n),
    .i_async  (slow_clk_in),
    .o_rise_c (w_rise),
    .o_fall_c (w_fall),
    .o_level  (w_level)
  );

  assign w_in_range = (r_cnt >= PW'(MIN_P)) && (r_cnt <= PW'(MAX_P));
  assign w_timeout  = (r_cnt == PW'(SAT_P)) && !w_rise;
  assign w_tracking = (r_state == ACQUIRE) || (r_state == LOCKED);

  // Period counter, captured period and the per-edge strobes.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_period <= '0;
      r_tick   <= 1'b0;
      r_pvalid <= 1'b0;
    end else begin
      r_tick   <= w_rise;
      r_pvalid <= w_rise && w_tracking;
      if (w_rise) begin
        r_period <= r_cnt;
        r_cnt    <= PW'(1);
      end else if (r_cnt != PW'(SAT_P)) begin
        r_cnt <= r_cnt + PW'(1);
      end
    end
  end

  // Lock FSM with registered locked/fault; a loss beats a same-cycle clear.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_good   <= '0;
      r_locked <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      if (clr_fault) begin
        r_fault <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= ACQUIRE;
            r_good  <= '0;
          end
        end
        ACQUIRE: begin
          if (w_rise) begin
            if (w_in_range) begin
              if (r_good == GW'(LOCK_COUNT - 1)) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_good   <= '0;
              end else begin
                r_good <= r_good + GW'(1);
              end
            end else begin
              r_good <= '0;
            end
          end else if (w_timeout) begin
            r_state <= IDLE;
          end
        end
        LOCKED: begin
          if ((w_rise && !w_in_range) || w_timeout) begin
            r_state  <= LOST;
            r_locked <= 1'b0;
            r_fault  <= 1'b1;
          end
        end
        LOST: begin
          if (w_rise) begin
            r_state <= ACQUIRE;
            r_good  <= '0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign tick         = r_tick;
  assign period_out   = r_period;
  assign period_valid = r_pvalid;
  assign locked       = r_locked;
  assign fault        = r_fault;

`ifdef TICK_MON_DUTY_EN
  logic [PW-1:0] r_high_cnt;
  logic [PW-1:0] r_high_out;

  // High-phase length: restart on rise, capture on fall, saturate.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_high_cnt <= '0;
      r_high_out <= '0;
    end else begin
      if (w_rise) begin
        r_high_cnt <= PW'(1);
      end else if (r_high_cnt != PW'(SAT_P)) begin
        r_high_cnt <= r_high_cnt + PW'(1);
      end
      if (w_fall) begin
        r_high_out <= r_high_cnt;
      end
    end
  end

  assign high_cnt_out = r_high_out;
  assign w_unused     = &{1'b0, w_level};
`else
  assign w_unused     = &{1'b0, w_level, w_fall};
`endif

endmodule

// File: tb/tb_tick_monitor.sv
// tb_tick_monitor: directed lock/loss scenarios plus randomized periods,
// checked every cycle against an event-level model of the monitor.
module tb_tick_monitor;

  localparam int SYNC  = 2;
  localparam int MINP  = 98;
  localparam int MAXP  = 102;
  localparam int SAT   = 103;
  localparam int LOCKN = 4;
  localparam int LOGN  = 2048;

  logic       clk_in;
  logic       rst_n = 1'b0;
  logic       slow_clk_in = 1'b0;
  logic       clr_fault = 1'b0;
  logic       tick;
  logic [6:0] period_out;
  logic       period_valid;
  logic       locked;
  logic       fault;
`ifdef TICK_MON_DUTY_EN
  logic [6:0] high_cnt_out;
`endif

  tick_monitor #(
    .SRC_FREQ_HZ    (100_000_000),
    .EXPECT_FREQ_HZ (1_000_000),
    .TOL_CYCLES     (2),
    .LOCK_COUNT     (LOCKN),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .slow_clk_in  (slow_clk_in),
    .clr_fault    (clr_fault),
    .tick         (tick),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .fault        (fault)
`ifdef TICK_MON_DUTY_EN
    ,
    .high_cnt_out (high_cnt_out)
`endif
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (event level) ----------------
  int mn, mprev, mrise, run;
  bit tracking, in_lock;
  bit hist[$];
  int m_tick = 0, m_pv = 0, m_po = 0, m_locked = 0, m_fault = 0, m_high = 0;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mn = 0; mprev = 1; mrise = 1; run = 0;
      tracking = 0; in_lock = 0;
      hist.delete();
      for (int i = 0; i < SYNC + 2; i++) hist.push_back(1'b0);
      m_tick = 0; m_pv = 0; m_po = 0; m_locked = 0; m_fault = 0; m_high = 0;
    end else begin
      int since, hsince;
      bit rise, fall, set_f, good;
      mn++;
      hist.push_back(slow_clk_in);
      void'(hist.pop_front());
      // hist[1] is the input sampled SYNC cycles ago, hist[0] one before that
      rise   = hist[1] && !hist[0];
      fall   = !hist[1] && hist[0];
      since  = (mn - mprev > SAT) ? SAT : mn - mprev;
      hsince = (mn - mrise > SAT) ? SAT : mn - mrise;
      good   = (since >= MINP) && (since <= MAXP);
      set_f  = 0;
      m_tick = rise;
      m_pv   = 0;
      if (rise) begin
        m_pv  = tracking;
        m_po  = since;
        mprev = mn;
        if (!tracking) begin
          tracking = 1; run = 0;
        end else if (!in_lock) begin
          run = good ? run + 1 : 0;
          if (run == LOCKN) begin in_lock = 1; run = 0; end
        end else if (!good) begin
          in_lock = 0; tracking = 0; set_f = 1;
        end
      end else if (since == SAT) begin
        if (in_lock) set_f = 1;
        in_lock = 0; tracking = 0;
      end
      m_locked = in_lock;
      if (set_f) m_fault = 1;
      else if (clr_fault) m_fault = 0;
      if (fall) m_high = hsince;
      if (rise) mrise = mn;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_in) begin
    chk("tick", int'(tick), m_tick);
    chk("period_out", int'(period_out), m_po);
    chk("period_valid", int'(period_valid), m_pv);
    chk("locked", int'(locked), m_locked);
    chk("fault", int'(fault), m_fault);
`ifdef TICK_MON_DUTY_EN
    chk("high_cnt_out", int'(high_cnt_out), m_high);
`endif
  end

  // ---------------- tick log for literal expectations ----------------
  int ev_locked[LOGN], ev_pv[LOGN], ev_po[LOGN], ev_fault[LOGN];
  int n_ev = 0, since_tick = 0, fall_since = -1;
  bit prev_locked = 0;

  always @(negedge clk_in) begin
    since_tick++;
    if (tick) begin
      if (n_ev < LOGN) begin
        ev_locked[n_ev] = int'(locked);
        ev_pv[n_ev]     = int'(period_valid);
        ev_po[n_ev]     = int'(period_out);
        ev_fault[n_ev]  = int'(fault);
      end
      n_ev++;
      since_tick = 0;
    end
    if (prev_locked && !locked) fall_since = since_tick;
    prev_locked = locked;
  end

  task automatic clear_log();
    n_ev = 0;
    fall_since = -1;
    for (int i = 0; i < LOGN; i++) begin
      ev_locked[i] = -1; ev_pv[i] = -1; ev_po[i] = -1; ev_fault[i] = -1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // One slow period starting with a rising edge. clr_mode: 0 none,
  // 1 pulse sampled on the same edge that registers this rise's tick,
  // 2 pulse well after the tick, 3 random sparse pulses.
  task automatic drive(input int hi, input int lo, input int clr_mode);
    for (int i = 0; i < hi + lo; i++) begin
      slow_clk_in = (i < hi);
      case (clr_mode)
        1:       clr_fault = (i == 2);
        2:       clr_fault = (i == 10);
        3:       clr_fault = ($urandom_range(0, 63) == 0);
        default: clr_fault = 1'b0;
      endcase
      cyc(1);
    end
    clr_fault = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    slow_clk_in = 1'b0;
    clr_fault = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    clear_log();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    do_reset();
    chk("reset_locked", int'(locked), 0);
    chk("reset_period", int'(period_out), 0);

    // Lock at nominal period 100
    repeat (8) drive(50, 50, 0);
    cyc(5);
    chk("t1_ticks", n_ev, 8);
    chk("t1_pv0", ev_pv[0], 0);
    chk("t1_pv1", ev_pv[1], 1);
    chk("t1_po1", ev_po[1], 100);
    chk("t1_lock4th", ev_locked[3], 0);
    chk("t1_lock5th", ev_locked[4], 1);
    chk("t1_po7", ev_po[7], 100);

    // Tolerance boundaries, then one period just out of range
    do_reset();
    drive(51, 51, 0); drive(49, 49, 0); drive(51, 51, 0); drive(49, 49, 0);
    drive(51, 52, 0); drive(50, 50, 0);
    cyc(5);
    chk("t2_lock4th", ev_locked[3], 0);
    chk("t2_lock5th", ev_locked[4], 1);
    chk("t2_po98", ev_po[4], 98);
    chk("t2_loss_locked", ev_locked[5], 0);
    chk("t2_loss_fault", ev_fault[5], 1);
    chk("t2_po103", ev_po[5], 103);

    // Stall after lock
    do_reset();
    repeat (6) drive(50, 50, 0);
    cyc(150);
    chk("t3_fall_delay", fall_since, 103);
    chk("t3_fault", int'(fault), 1);
    snap = n_ev;
    chk("t3_ticks", snap, 6);
    cyc(1000);
    chk("t3_no_tick", n_ev, snap);
    chk("t3_po_hold", int'(period_out), 100);

    // Re-acquire from LOST, clear alone, loss with simultaneous clear
    clear_log();
    repeat (6) drive(50, 50, 0);
    drive(50, 50, 2);
    drive(51, 52, 0);
    drive(50, 50, 1);
    drive(50, 50, 2);
    chk("t4_ticks", n_ev, 10);
    chk("t4_pv0", ev_pv[0], 0);
    chk("t4_lock5th", ev_locked[4], 1);
    chk("t4_fault_sticky", ev_fault[6], 1);
    chk("t4_fault_cleared", ev_fault[7], 0);
    chk("t4_set_wins", ev_fault[8], 1);
    chk("t4_loss_locked", ev_locked[8], 0);
    chk("t4_clear_alone", int'(fault), 0);
    cyc(5);

    // Asynchronous reset mid-acquire
    do_reset();
    repeat (3) drive(50, 50, 0);
    chk("t5_ticks_pre", n_ev, 3);
    chk("t5_po_pre", int'(period_out), 100);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tick", int'(tick), 0);
    chk("t5_rst_po", int'(period_out), 0);
    chk("t5_rst_pv", int'(period_valid), 0);
    chk("t5_rst_locked", int'(locked), 0);
    chk("t5_rst_fault", int'(fault), 0);
    @(posedge clk_in);
    #1;
    cyc(2);
    rst_n = 1'b1;
    clear_log();
    repeat (6) drive(50, 50, 0);
    cyc(5);
    chk("t5_pv0", ev_pv[0], 0);
    chk("t5_lock4th", ev_locked[3], 0);
    chk("t5_lock5th", ev_locked[4], 1);

`ifdef TICK_MON_DUTY_EN
    // Duty measurement
    do_reset();
    repeat (4) drive(30, 70, 0);
    cyc(5);
    chk("t6_high", int'(high_cnt_out), 30);
    chk("t6_po", int'(period_out), 100);
`endif

    // Randomized periods, duties, stalls and clears
    do_reset();
    repeat (200) begin
      int r, p, hi;
      r = int'($urandom_range(0, 99));
      if (r < 75)      p = int'($urandom_range(97, 103));
      else if (r < 92) p = int'($urandom_range(40, 160));
      else             p = int'($urandom_range(104, 400));
      hi = int'($urandom_range(1, p - 1));
      drive(hi, p - hi, 3);
    end
    cyc(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
